// File: rtl/dmac_bus_arbiter.sv
// Two-master AHB arbiter: the CPU is the default/parking master and the DMAC
// borrows the bus. Ownership moves only at idle transfer boundaries. A waiting
// CPU bounds DMAC tenure. After a preemption, a fairness window keeps the
// DMAC off the bus while the CPU keeps requesting.
module dmac_bus_arbiter #(
   parameter int MAX_GRANT_CYCLES = 16,
   parameter int CW               = $clog2(MAX_GRANT_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic cpu_req,
   input  logic cpu_lock,
   input  logic dma_req,
   input  logic hready,
   input  logic [1:0] htrans,
   output logic grant_cpu,
   output logic grant_dma,
   output logic hmaster,
   output logic hmastlock,
   output logic preempt
);

   typedef enum logic [1:0] {
      PARK_CPU = 2'b00,
      OWN_DMA  = 2'b01,
      DRAIN    = 2'b10
   } state_t;

   localparam logic [CW-1:0] TEN_LAST = CW'(MAX_GRANT_CYCLES - 1);
   localparam logic [CW-1:0] TEN_MAX  = CW'(MAX_GRANT_CYCLES);

   state_t        state;
   logic [CW-1:0] ten_cnt;
   logic [CW-1:0] fair_cnt;
   logic          bnd;

   // An idle transfer that completes is the only safe point to switch owners.
   assign bnd = hready & (htrans == 2'b00);

   // The lock is only meaningful while the CPU drives the address phase.
   assign hmastlock = cpu_lock & ~hmaster;

   // Arbitration FSM with registered grants, owner select and preempt pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PARK_CPU;
         grant_cpu <= 1'b1;
         grant_dma <= 1'b0;
         hmaster   <= 1'b0;
         preempt   <= 1'b0;
         ten_cnt   <= '0;
         fair_cnt  <= '0;
      end else begin
         preempt <= 1'b0;
         case (state)
            PARK_CPU: begin
               // The fairness window only runs down while the CPU actually wants the bus.
               if (!cpu_req)
                  fair_cnt <= '0;
               else if (fair_cnt != '0)
                  fair_cnt <= fair_cnt - CW'(1);
               if (dma_req && !cpu_lock && bnd && (fair_cnt == '0)) begin
                  state     <= OWN_DMA;
                  grant_cpu <= 1'b0;
                  grant_dma <= 1'b1;
                  hmaster   <= 1'b1;
                  ten_cnt   <= '0;
               end
            end
            OWN_DMA: begin
               if (!dma_req && bnd) begin
                  // A voluntary release wins over expiry, so no fairness window applies.
                  state     <= PARK_CPU;
                  grant_cpu <= 1'b1;
                  grant_dma <= 1'b0;
                  hmaster   <= 1'b0;
               end else if (cpu_req && (ten_cnt == TEN_LAST)) begin
                  // Take the grant away but keep the mux on the DMAC until its burst ends.
                  state     <= DRAIN;
                  grant_dma <= 1'b0;
                  preempt   <= 1'b1;
               end else if (cpu_req && (ten_cnt != TEN_MAX)) begin
                  ten_cnt <= ten_cnt + CW'(1);
               end
            end
            DRAIN: begin
               if (bnd) begin
                  state     <= PARK_CPU;
                  grant_cpu <= 1'b1;
                  hmaster   <= 1'b0;
                  fair_cnt  <= TEN_MAX;
               end
            end
            default: begin
               state     <= PARK_CPU;
               grant_cpu <= 1'b1;
               grant_dma <= 1'b0;
               hmaster   <= 1'b0;
               ten_cnt   <= '0;
               fair_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// Directed bench for dmac_bus_arbiter with MAX_GRANT_CYCLES=4.
module tb_dmac_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic cpu_req, cpu_lock, dma_req, hready;
   logic [1:0] htrans;
   logic grant_cpu, grant_dma, hmaster, hmastlock, preempt;

   int total = 0;
   int bad   = 0;

   dmac_bus_arbiter #(.MAX_GRANT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_lock(cpu_lock),
      .dma_req(dma_req), .hready(hready), .htrans(htrans),
      .grant_cpu(grant_cpu), .grant_dma(grant_dma), .hmaster(hmaster),
      .hmastlock(hmastlock), .preempt(preempt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {grant_cpu, grant_dma, hmaster, preempt}
   task automatic chk_out(input string tag, input logic [3:0] exp);
      chk(tag, {4'h0, grant_cpu, grant_dma, hmaster, preempt}, {4'h0, exp});
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_lock = 1'b0; dma_req = 1'b0;
      hready = 1'b1; htrans = 2'b00;
      #3;
      chk_out("reset_outputs", 4'b1000);
      cpu_lock = 1'b1; #1;
      chk("reset_hmastlock", {7'h0, hmastlock}, 8'h1);
      cpu_lock = 1'b0;
      tick();
      rst = 1'b0;

      // Park with no requests.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_out("idle_park", 4'b1000);
      end

      // Basic handover and release.
      dma_req = 1'b1;
      tick(); chk_out("basic_grant", 4'b0110);
      tick(); tick(); chk_out("basic_hold", 4'b0110);
      dma_req = 1'b0;
      tick(); chk_out("basic_release", 4'b1000);

      // Boundary hold-off on a non-idle transfer.
      dma_req = 1'b1; htrans = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick(); chk_out("holdoff_seq", 4'b1000);
      end
      htrans = 2'b00;
      tick(); chk_out("holdoff_seq_grant", 4'b0110);
      dma_req = 1'b0;
      tick(); chk_out("holdoff_seq_release", 4'b1000);

      // Boundary hold-off on wait states.
      dma_req = 1'b1; hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("holdoff_stall", 4'b1000);
      end
      hready = 1'b1;
      tick(); chk_out("holdoff_stall_grant", 4'b0110);
      dma_req = 1'b0;
      tick(); chk_out("holdoff_stall_release", 4'b1000);

      // Locked CPU sequence blocks handover.
      cpu_lock = 1'b1; dma_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_out("lock_block", 4'b1000);
         chk("lock_hmastlock", {7'h0, hmastlock}, 8'h1);
      end
      cpu_lock = 1'b0;
      tick(); chk_out("lock_release_grant", 4'b0110);
      cpu_lock = 1'b1; #1;
      chk("hmastlock_dma_owner", {7'h0, hmastlock}, 8'h0);
      cpu_lock = 1'b0;

      // Asynchronous reset mid-tenure.
      rst = 1'b1; #1;
      chk_out("async_reset_mid_tenure", 4'b1000);
      dma_req = 1'b0;
      tick();
      rst = 1'b0;
      tick(); chk_out("post_reset_park", 4'b1000);

      // Preemption: DMAC takes bus with the CPU waiting.
      dma_req = 1'b1; cpu_req = 1'b1;
      tick(); chk_out("pre_grant", 4'b0110);
      htrans = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("pre_tenure", 4'b0110);
      end
      tick(); chk_out("pre_expire", 4'b0011);
      tick(); chk_out("pre_drain", 4'b0010);
      htrans = 2'b00;
      tick(); chk_out("pre_drain_done", 4'b1000);

      // Fairness window: four CPU-request cycles before the DMAC returns.
      for (int i = 0; i < 4; i++) begin
         tick(); chk_out("fair_window", 4'b1000);
      end
      tick(); chk_out("fair_regrant", 4'b0110);

      // Second preemption, then the CPU drops its request.
      htrans = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("pre2_tenure", 4'b0110);
      end
      tick(); chk_out("pre2_expire", 4'b0011);
      htrans = 2'b00;
      tick(); chk_out("pre2_drain_done", 4'b1000);
      cpu_req = 1'b0;
      tick(); chk_out("fair_clear", 4'b1000);
      tick(); chk_out("fair_clear_grant", 4'b0110);

      // Request drop in the expiry cycle wins over preemption.
      cpu_req = 1'b1; htrans = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("sim_tenure", 4'b0110);
      end
      dma_req = 1'b0; htrans = 2'b00;
      tick(); chk_out("sim_drop_wins", 4'b1000);
      dma_req = 1'b1;
      tick(); chk_out("sim_regrant", 4'b0110);
      tick(); chk_out("sim_no_late_pulse", 4'b0110);

      dma_req = 1'b0; cpu_req = 1'b0;
      tick(); chk_out("final_park", 4'b1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
